// File: rtl/mul_err_scanner.sv
// mul_err_scanner
//   Exhaustive error-characterisation controller for a combinational
//   WIDTH x WIDTH approximate multiplier. Every operand pair (A outer loop,
//   B inner loop) is driven on mul_a/mul_b. The returned product is compared
//   with the exact product through a two-stage pipeline:
//     stage 1 : signed error e = mul_p - a*b, nonzero flag, operand pair
//     stage 2 : sse += e^2, err_cnt += (e != 0), max |e| with first worst pair
//
// Ports
//   clk, rst          clock (rising edge), asynchronous active-high reset
//   start             begin a sweep (honoured only when busy = 0)
//   abort             terminate a running sweep (ignored when busy = 0)
//   busy / done       sweep in progress / results valid (level)
//   mul_a, mul_b      registered operands to the multiplier under test
//   mul_p             product returned by the multiplier under test
//   sse               sum of squared errors
//   max_err           maximum absolute error
//   worst_a, worst_b  first operand pair that reached max_err
//   err_cnt           number of pairs whose product was wrong
//   dbg_state         current FSM state (IDLE=0, RUN=1, DRAIN=2, DONE=3)
//
// Handshake: start is a level sampled on rising clk edges; it is accepted on
// any edge where busy = 0 (IDLE or DONE), and then wins over a simultaneous
// abort. abort is accepted on any edge where busy = 1 and discards everything
// still in flight, including the pair that would accumulate on that edge.
module mul_err_scanner #(
  parameter int WIDTH = 8,
  parameter int SSE_W = 6 * WIDTH
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 abort,
  output logic                 busy,
  output logic                 done,
  output logic [WIDTH-1:0]     mul_a,
  output logic [WIDTH-1:0]     mul_b,
  input  logic [2*WIDTH-1:0]   mul_p,
  output logic [SSE_W-1:0]     sse,
  output logic [2*WIDTH-1:0]   max_err,
  output logic [WIDTH-1:0]     worst_a,
  output logic [WIDTH-1:0]     worst_b,
  output logic [2*WIDTH:0]     err_cnt,
  output logic [1:0]           dbg_state
);

  localparam int PW  = 2 * WIDTH;  // product width
  localparam int EW  = PW + 1;     // signed error width
  localparam int SQW = 2 * PW;     // squared error width
  localparam logic [WIDTH-1:0] OP_MAX = '1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t state_q, state_d;

  logic [WIDTH-1:0] mul_a_q, mul_a_d;
  logic [WIDTH-1:0] mul_b_q, mul_b_d;

  logic             s1_vld_q, s1_vld_d;
  logic [EW-1:0]    s1_err_q, s1_err_d;
  logic             s1_nz_q, s1_nz_d;
  logic [WIDTH-1:0] s1_a_q, s1_a_d;
  logic [WIDTH-1:0] s1_b_q, s1_b_d;

  logic [SSE_W-1:0] sse_q, sse_d;
  logic [PW-1:0]    max_q, max_d;
  logic [WIDTH-1:0] wa_q, wa_d;
  logic [WIDTH-1:0] wb_q, wb_d;
  logic [2*WIDTH:0] cnt_q, cnt_d;

  logic          busy_w;
  logic          start_acc;
  logic          abort_acc;
  logic          last_issued;
  logic          acc_en;
  logic [PW-1:0] exact_p;
  logic [EW-1:0] neg_err;
  logic [PW-1:0] abs_err;
  logic [SQW-1:0] sq_err;

  assign busy_w      = (state_q == S_RUN) || (state_q == S_DRAIN);
  assign start_acc   = start && !busy_w;
  assign abort_acc   = abort && busy_w;
  // The pair currently on mul_a/mul_b is the final one of the sweep.
  assign last_issued = (mul_a_q == OP_MAX) && (mul_b_q == OP_MAX);

  // ---------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // ---------------------------------------------------------------------
  // FSM: next state
  // ---------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:  if (start) state_d = S_RUN;
      S_RUN: begin
        if (abort)            state_d = S_IDLE;
        else if (last_issued) state_d = S_DRAIN;
      end
      // DRAIN lasts one cycle: the last pair sits in stage 1 and is
      // accumulated on the edge that enters DONE.
      S_DRAIN: state_d = abort ? S_IDLE : S_DONE;
      S_DONE:  if (start) state_d = S_RUN;
      default: state_d = S_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------
  // FSM: outputs
  // ---------------------------------------------------------------------
  always_comb begin
    busy      = busy_w;
    done      = (state_q == S_DONE);
    dbg_state = state_q;
  end

  // ---------------------------------------------------------------------
  // Operand enumeration: B inner loop, A outer loop. Operands are parked at
  // zero whenever no pair is being issued.
  // ---------------------------------------------------------------------
  always_comb begin
    mul_a_d = '0;
    mul_b_d = '0;
    if (!start_acc && (state_q == S_RUN) && !abort && !last_issued) begin
      mul_b_d = mul_b_q + WIDTH'(1);
      mul_a_d = (mul_b_q == OP_MAX) ? mul_a_q + WIDTH'(1) : mul_a_q;
    end
  end

  // ---------------------------------------------------------------------
  // Stage 1: signed error of the pair currently driven
  // ---------------------------------------------------------------------
  assign exact_p = PW'(mul_a_q) * PW'(mul_b_q);

  always_comb begin
    s1_vld_d = (state_q == S_RUN) && !abort;
    s1_err_d = {1'b0, mul_p} - {1'b0, exact_p};
    s1_nz_d  = (mul_p != exact_p);
    s1_a_d   = mul_a_q;
    s1_b_d   = mul_b_q;
  end

  // ---------------------------------------------------------------------
  // Stage 2: accumulation
  // ---------------------------------------------------------------------
  // |e| never exceeds 2^PW - 1, so the magnitude fits in PW bits.
  assign neg_err = -s1_err_q;
  assign abs_err = s1_err_q[EW-1] ? neg_err[PW-1:0] : s1_err_q[PW-1:0];
  assign sq_err  = SQW'(abs_err) * SQW'(abs_err);
  assign acc_en  = s1_vld_q && !abort_acc;

  always_comb begin
    sse_d = sse_q;
    max_d = max_q;
    wa_d  = wa_q;
    wb_d  = wb_q;
    cnt_d = cnt_q;
    if (start_acc) begin
      sse_d = '0;
      max_d = '0;
      wa_d  = '0;
      wb_d  = '0;
      cnt_d = '0;
    end else if (acc_en) begin
      sse_d = sse_q + SSE_W'(sq_err);
      if (s1_nz_q) cnt_d = cnt_q + (2*WIDTH+1)'(1);
      // Strictly greater: ties keep the earliest pair.
      if (abs_err > max_q) begin
        max_d = abs_err;
        wa_d  = s1_a_q;
        wb_d  = s1_b_q;
      end
    end
  end

  // ---------------------------------------------------------------------
  // Datapath registers
  // ---------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mul_a_q  <= '0;
      mul_b_q  <= '0;
      s1_vld_q <= 1'b0;
      s1_err_q <= '0;
      s1_nz_q  <= 1'b0;
      s1_a_q   <= '0;
      s1_b_q   <= '0;
      sse_q    <= '0;
      max_q    <= '0;
      wa_q     <= '0;
      wb_q     <= '0;
      cnt_q    <= '0;
    end else begin
      mul_a_q  <= mul_a_d;
      mul_b_q  <= mul_b_d;
      s1_vld_q <= s1_vld_d;
      s1_err_q <= s1_err_d;
      s1_nz_q  <= s1_nz_d;
      s1_a_q   <= s1_a_d;
      s1_b_q   <= s1_b_d;
      sse_q    <= sse_d;
      max_q    <= max_d;
      wa_q     <= wa_d;
      wb_q     <= wb_d;
      cnt_q    <= cnt_d;
    end
  end

  assign mul_a   = mul_a_q;
  assign mul_b   = mul_b_q;
  assign sse     = sse_q;
  assign max_err = max_q;
  assign worst_a = wa_q;
  assign worst_b = wb_q;
  assign err_cnt = cnt_q;

endmodule

// File: tb/tb_mul_err_scanner.sv
// Bench for mul_err_scanner. Two instances share one clock:
//   u_big   : WIDTH=8, one full sweep against a stuck-at-zero multiplier
//   u_small : WIDTH=4, every other scenario (short 257-cycle sweeps)
// The approximate multipliers are modelled combinationally in the bench.
// Expected results are pushed to a queue when a sweep is started and popped
// when done rises.
module tb_mul_err_scanner;

  typedef struct packed {
    logic [47:0] sse;
    logic [15:0] mx;
    logic [7:0]  wa;
    logic [7:0]  wb;
    logic [16:0] cnt;
  } res_t;

  // ------------------------------------------------------------------
  // Clock / reset
  // ------------------------------------------------------------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic b_rst = 1'b1;
  logic s_rst = 1'b1;

  // ------------------------------------------------------------------
  // DUT signals
  // ------------------------------------------------------------------
  logic        b_start = 1'b0, b_abort = 1'b0, b_busy, b_done;
  logic [7:0]  b_mul_a, b_mul_b, b_wa, b_wb;
  logic [15:0] b_mul_p, b_max;
  logic [47:0] b_sse;
  logic [16:0] b_cnt;
  logic [1:0]  b_state;
  int          b_mode = 0;

  logic        s_start = 1'b0, s_abort = 1'b0, s_busy, s_done;
  logic [3:0]  s_mul_a, s_mul_b, s_wa, s_wb;
  logic [7:0]  s_mul_p, s_max;
  logic [23:0] s_sse;
  logic [8:0]  s_cnt;
  logic [1:0]  s_state;
  int          s_mode = 0;
  longint      s_xm = 0;

  res_t b_exp_q[$];
  res_t s_exp_q[$];

  int n_checks = 0;
  int n_errors = 0;

  // ------------------------------------------------------------------
  // Multiplier-under-test models
  //   0 exact, 1 stuck-at-zero, 2 exact+1, 3 exact xor mask
  // ------------------------------------------------------------------
  function automatic longint approx(input int mode, input longint a, input longint b,
                                    input int w, input longint xm);
    longint m;
    longint p;
    m = (longint'(1) << (2 * w)) - 1;
    case (mode)
      0:       p = a * b;
      1:       p = 0;
      2:       p = a * b + 1;
      default: p = (a * b) ^ xm;
    endcase
    return p & m;
  endfunction

  function automatic res_t model(input int mode, input int w, input longint xm);
    res_t   r;
    longint n, p, e, ae;
    r = '0;
    n = longint'(1) << w;
    for (longint a = 0; a < n; a++) begin
      for (longint b = 0; b < n; b++) begin
        p  = approx(mode, a, b, w, xm);
        e  = p - a * b;
        ae = (e < 0) ? -e : e;
        r.sse = r.sse + 48'(ae * ae);
        if (e != 0) r.cnt = r.cnt + 17'd1;
        if (ae > longint'(r.mx)) begin
          r.mx = 16'(ae);
          r.wa = 8'(a);
          r.wb = 8'(b);
        end
      end
    end
    return r;
  endfunction

  always_comb b_mul_p = 16'(approx(b_mode, longint'(b_mul_a), longint'(b_mul_b), 8, 0));
  always_comb s_mul_p = 8'(approx(s_mode, longint'(s_mul_a), longint'(s_mul_b), 4, s_xm));

  mul_err_scanner #(.WIDTH(8)) u_big (
    .clk(clk), .rst(b_rst), .start(b_start), .abort(b_abort),
    .busy(b_busy), .done(b_done), .mul_a(b_mul_a), .mul_b(b_mul_b),
    .mul_p(b_mul_p), .sse(b_sse), .max_err(b_max), .worst_a(b_wa),
    .worst_b(b_wb), .err_cnt(b_cnt), .dbg_state(b_state)
  );

  mul_err_scanner #(.WIDTH(4)) u_small (
    .clk(clk), .rst(s_rst), .start(s_start), .abort(s_abort),
    .busy(s_busy), .done(s_done), .mul_a(s_mul_a), .mul_b(s_mul_b),
    .mul_p(s_mul_p), .sse(s_sse), .max_err(s_max), .worst_a(s_wa),
    .worst_b(s_wb), .err_cnt(s_cnt), .dbg_state(s_state)
  );

  // ------------------------------------------------------------------
  // Checking
  // ------------------------------------------------------------------
  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic check_small_zero(input string tag);
    check({tag, "_busy"}, 64'(s_busy), 0);
    check({tag, "_done"}, 64'(s_done), 0);
    check({tag, "_mul_a"}, 64'(s_mul_a), 0);
    check({tag, "_mul_b"}, 64'(s_mul_b), 0);
    check({tag, "_sse"}, 64'(s_sse), 0);
    check({tag, "_max"}, 64'(s_max), 0);
    check({tag, "_wa"}, 64'(s_wa), 0);
    check({tag, "_wb"}, 64'(s_wb), 0);
    check({tag, "_cnt"}, 64'(s_cnt), 0);
  endtask

  // ------------------------------------------------------------------
  // Driver: one full sweep on the small instance. Called at a negedge with
  // the DUT idle or done. poke drives a stray start 50 cycles in; with_abort
  // raises abort together with start.
  // ------------------------------------------------------------------
  task automatic s_sweep(input string tag, input int mode, input longint xm,
                         input bit poke, input bit with_abort);
    res_t exp;
    int   cyc;
    s_mode = mode;
    s_xm   = xm;
    s_exp_q.push_back(model(mode, 4, xm));
    s_start = 1'b1;
    s_abort = with_abort;
    @(negedge clk);
    s_start = 1'b0;
    s_abort = 1'b0;
    check({tag, "_clr_cnt"}, 64'(s_cnt), 0);
    check({tag, "_clr_sse"}, 64'(s_sse), 0);
    check({tag, "_busy_up"}, 64'(s_busy), 1);
    cyc = 0;
    while (s_busy && cyc < 400) begin
      cyc++;
      s_start = poke && (cyc == 50);
      @(negedge clk);
    end
    s_start = 1'b0;
    check({tag, "_busy_cycles"}, 64'(cyc), 257);
    check({tag, "_done"}, 64'(s_done), 1);
    check({tag, "_mul_a"}, 64'(s_mul_a), 0);
    check({tag, "_mul_b"}, 64'(s_mul_b), 0);
    if (s_exp_q.size() == 0) begin
      check({tag, "_queue"}, 0, 1);
    end else begin
      exp = s_exp_q.pop_front();
      check({tag, "_sse"}, 64'(s_sse), 64'(exp.sse));
      check({tag, "_max"}, 64'(s_max), 64'(exp.mx));
      check({tag, "_wa"}, 64'(s_wa), 64'(exp.wa));
      check({tag, "_wb"}, 64'(s_wb), 64'(exp.wb));
      check({tag, "_cnt"}, 64'(s_cnt), 64'(exp.cnt));
    end
  endtask

  // ------------------------------------------------------------------
  // Full-width sweep: stuck-at-zero multiplier
  // ------------------------------------------------------------------
  task automatic big_flow();
    res_t exp;
    int   cyc;
    b_mode = 1;
    b_exp_q.push_back('{sse: 48'd30910041702400, mx: 16'd65025, wa: 8'd255,
                        wb: 8'd255, cnt: 17'd65025});
    b_start = 1'b1;
    @(negedge clk);
    b_start = 1'b0;
    cyc = 0;
    while (b_busy && cyc < 70000) begin
      cyc++;
      @(negedge clk);
    end
    check("big_busy_cycles", 64'(cyc), 65537);
    check("big_done", 64'(b_done), 1);
    exp = b_exp_q.pop_front();
    check("big_sse", 64'(b_sse), 64'(exp.sse));
    check("big_max", 64'(b_max), 64'(exp.mx));
    check("big_wa", 64'(b_wa), 64'(exp.wa));
    check("big_wb", 64'(b_wb), 64'(exp.wb));
    check("big_cnt", 64'(b_cnt), 64'(exp.cnt));
  endtask

  // ------------------------------------------------------------------
  // Small-instance scenarios
  // ------------------------------------------------------------------
  task automatic small_flow();
    s_sweep("exact", 0, 0, 1'b0, 1'b0);
    // Restart in the first done cycle, different model
    s_sweep("zero", 1, 0, 1'b0, 1'b0);
    // Stray start mid-sweep must not disturb the count
    s_sweep("plus1_poke", 2, 0, 1'b1, 1'b0);
    // start + abort together in DONE: start wins
    s_sweep("plus1_sa", 2, 0, 1'b0, 1'b1);
    s_sweep("xor_a", 3, longint'($urandom_range(1, 255)), 1'b0, 1'b0);
    s_sweep("xor_b", 3, longint'($urandom_range(1, 255)), 1'b0, 1'b0);

    // Abort sampled 150 edges after start: pairs 0..147 accumulated
    s_mode  = 2;
    s_start = 1'b1;
    @(negedge clk);
    s_start = 1'b0;
    repeat (149) @(negedge clk);
    s_abort = 1'b1;
    @(negedge clk);
    s_abort = 1'b0;
    check("abort_busy", 64'(s_busy), 0);
    check("abort_done", 64'(s_done), 0);
    check("abort_mul_a", 64'(s_mul_a), 0);
    check("abort_mul_b", 64'(s_mul_b), 0);
    check("abort_cnt", 64'(s_cnt), 148);
    check("abort_sse", 64'(s_sse), 148);
    check("abort_max", 64'(s_max), 1);
    repeat (3) @(negedge clk);
    check("abort_hold_cnt", 64'(s_cnt), 148);
    check("abort_hold_state", 64'(s_state), 0);

    // abort while idle is ignored
    s_abort = 1'b1;
    @(negedge clk);
    s_abort = 1'b0;
    check("idle_abort_cnt", 64'(s_cnt), 148);
    check("idle_abort_busy", 64'(s_busy), 0);

    // Asynchronous reset 100 cycles into a sweep
    s_start = 1'b1;
    @(negedge clk);
    s_start = 1'b0;
    repeat (99) @(negedge clk);
    check("pre_rst_busy", 64'(s_busy), 1);
    #2 s_rst = 1'b1;
    #1 check_small_zero("rst_mid");
    @(negedge clk);
    s_rst = 1'b0;
    s_sweep("after_rst", 2, 0, 1'b0, 1'b0);
  endtask

  initial begin
    repeat (2) @(negedge clk);
    check_small_zero("reset_small");
    check("reset_big_busy", 64'(b_busy), 0);
    check("reset_big_cnt", 64'(b_cnt), 0);
    check("reset_big_sse", 64'(b_sse), 0);
    b_rst = 1'b0;
    s_rst = 1'b0;
    @(negedge clk);
    fork
      big_flow();
      small_flow();
    join
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
